// File: rtl/hash_display_sequencer_if.sv
// Handshake bundle between the hash/button sources and the display select sequencer.
// The slave modport is the sequencer; the master modport is whatever drives it.
interface hash_display_sequencer_if;
  logic       hash_valid;
  logic       btn_next;
  logic       btn_prev;
  logic       auto_en;
  logic       show_normal;
  logic [3:0] control;
  logic       hash_ready;
  logic       wrap_done;

  modport master (
    output hash_valid, btn_next, btn_prev, auto_en, show_normal,
    input  control, hash_ready, wrap_done
  );

  modport slave (
    input  hash_valid, btn_next, btn_prev, auto_en, show_normal,
    output control, hash_ready, wrap_done
  );
endinterface

// File: rtl/hash_display_sequencer.sv
// Selects normal data or one of the hash words for the display mux.
// Steps through the words on a dwell timer (AUTO) or on next/prev pulses (MANUAL).
module hash_display_sequencer #(
  parameter int DWELL_CYCLES = 100_000_000,
  parameter int NUM_WORDS    = 8,
  parameter int CNT_W        = 27
) (
  input  logic                    clk,
  input  logic                    rst,
  hash_display_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    ST_NORMAL = 2'd0,
    ST_MANUAL = 2'd1,
    ST_AUTO   = 2'd2
  } state_t;

  localparam logic [3:0]       LAST_WORD  = 4'(NUM_WORDS);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);

  state_t           state;
  state_t           state_next;
  logic [3:0]       idx;
  logic [3:0]       idx_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             wrap_next;
  logic             step;
  logic [3:0]       control_q;
  logic             hash_ready_q;
  logic             wrap_done_q;

  function automatic logic [3:0] word_inc(input logic [3:0] w);
    word_inc = (w == LAST_WORD) ? 4'd1 : w + 4'd1;
  endfunction

  function automatic logic [3:0] word_dec(input logic [3:0] w);
    word_dec = (w == 4'd1) ? LAST_WORD : w - 4'd1;
  endfunction

  // Both buttons in one cycle cancel out.
  assign step = bus.btn_next ^ bus.btn_prev;

  always_comb begin
    state_next = state;
    idx_next   = idx;
    cnt_next   = cnt;
    wrap_next  = 1'b0;
    if (bus.show_normal) begin
      state_next = ST_NORMAL;
    end else if (bus.hash_valid) begin
      state_next = bus.auto_en ? ST_AUTO : ST_MANUAL;
      idx_next   = 4'd1;
      cnt_next   = '0;
    end else begin
      case (state)
        ST_NORMAL: begin
          // Leaving a forced-normal period resumes the held word unless a button restarts at word 1.
          if (hash_ready_q) begin
            state_next = bus.auto_en ? ST_AUTO : ST_MANUAL;
            cnt_next   = '0;
            if (bus.btn_next || bus.btn_prev) begin
              idx_next = 4'd1;
            end else begin
              idx_next = idx;
            end
          end else begin
            state_next = ST_NORMAL;
          end
        end
        ST_MANUAL, ST_AUTO: begin
          state_next = bus.auto_en ? ST_AUTO : ST_MANUAL;
          if (step) begin
            idx_next = bus.btn_next ? word_inc(idx) : word_dec(idx);
            cnt_next = '0;
          end else if (state == ST_AUTO && bus.auto_en) begin
            if (cnt == DWELL_LAST) begin
              cnt_next  = '0;
              idx_next  = word_inc(idx);
              wrap_next = (idx == LAST_WORD);
            end else begin
              cnt_next = cnt + CNT_W'(1);
            end
          end else begin
            cnt_next = '0;
          end
        end
        default: begin
          state_next = ST_NORMAL;
          idx_next   = 4'd1;
          cnt_next   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_NORMAL;
      idx          <= 4'd1;
      cnt          <= '0;
      control_q    <= 4'd0;
      hash_ready_q <= 1'b0;
      wrap_done_q  <= 1'b0;
    end else begin
      state        <= state_next;
      idx          <= idx_next;
      cnt          <= cnt_next;
      control_q    <= (state_next == ST_NORMAL) ? 4'd0 : idx_next;
      hash_ready_q <= hash_ready_q | (bus.hash_valid & ~bus.show_normal);
      wrap_done_q  <= wrap_next;
    end
  end

  assign bus.control    = control_q;
  assign bus.hash_ready = hash_ready_q;
  assign bus.wrap_done  = wrap_done_q;

endmodule

// File: tb/tb_hash_display_sequencer.sv
// Directed and random checks of hash_display_sequencer against a word/mode reference model.
module tb_hash_display_sequencer;

  localparam int DWELL = 4;
  localparam int WORDS = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: mode 0 = normal, 1 = manual, 2 = auto
  int   m_mode = 0;
  int   m_word = 1;
  int   m_elapsed = 0;
  bit   m_ready = 1'b0;
  bit   m_wrap = 1'b0;
  int   prev_control = 0;
  int   wraps_seen = 0;

  hash_display_sequencer_if bus ();

  hash_display_sequencer #(
    .DWELL_CYCLES(DWELL),
    .NUM_WORDS   (WORDS),
    .CNT_W       (3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int want);
    vectors++;
    assert (got === want) else begin
      miscompares++;
      $error("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_word = 1; m_elapsed = 0; m_ready = 1'b0; m_wrap = 1'b0;
  endtask

  task automatic model_step(input bit sn, input bit hv, input bit bn, input bit bp, input bit ae);
    m_wrap = 1'b0;
    if (sn) begin
      m_mode = 0;
    end else if (hv) begin
      m_ready = 1'b1; m_word = 1; m_elapsed = 0; m_mode = ae ? 2 : 1;
    end else if (m_mode == 0) begin
      if (m_ready) begin
        if (bn || bp) m_word = 1;
        m_elapsed = 0;
        m_mode = ae ? 2 : 1;
      end
    end else begin
      if (bn && !bp) begin
        m_word = m_word % WORDS + 1; m_elapsed = 0;
      end else if (bp && !bn) begin
        m_word = (m_word + WORDS - 2) % WORDS + 1; m_elapsed = 0;
      end else if (m_mode == 2 && ae) begin
        m_elapsed++;
        if (m_elapsed == DWELL) begin
          m_elapsed = 0;
          m_wrap = (m_word == WORDS);
          m_word = m_word % WORDS + 1;
        end
      end else begin
        m_elapsed = 0;
      end
      m_mode = ae ? 2 : 1;
    end
  endtask

  // One clock: drive inputs, advance the model, then compare just after the edge.
  task automatic step(input bit sn, input bit hv, input bit bn, input bit bp, input bit ae);
    bus.show_normal = sn; bus.hash_valid = hv; bus.btn_next = bn; bus.btn_prev = bp; bus.auto_en = ae;
    prev_control = int'(bus.control);
    model_step(sn, hv, bn, bp, ae);
    @(posedge clk);
    #1;
    chk("control", int'(bus.control), (m_mode == 0) ? 0 : m_word);
    chk("hash_ready", int'(bus.hash_ready), int'(m_ready));
    chk("wrap_done", int'(bus.wrap_done), int'(m_wrap));
    chk("control_range", int'(bus.control <= 4'd8), 1);
    if (bus.wrap_done) begin
      wraps_seen++;
      chk("wrap_edge", int'(prev_control == 8 && bus.control == 4'd1), 1);
    end
  endtask

  task automatic idle(input int n, input bit ae);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, ae);
  endtask

  initial begin
    bus.show_normal = 1'b0; bus.hash_valid = 1'b0; bus.btn_next = 1'b0;
    bus.btn_prev = 1'b0; bus.auto_en = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_control", int'(bus.control), 0);
    chk("reset_ready", int'(bus.hash_ready), 0);
    chk("reset_wrap", int'(bus.wrap_done), 0);
    rst = 1'b0;

    // Buttons before any hash are ignored
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("pre_hash_buttons", int'(bus.control), 0);

    // Auto scroll through all words and back to word 1
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("auto_first", int'(bus.control), 1);
    wraps_seen = 0;
    idle(WORDS * DWELL, 1'b1);
    chk("auto_wrapped_to_1", int'(bus.control), 1);
    chk("auto_wrap_count", wraps_seen, 1);

    // Reach word 5 then reset asynchronously mid-cycle
    idle(4 * DWELL, 1'b1);
    chk("auto_word5", int'(bus.control), 5);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_control", int'(bus.control), 0);
    chk("async_rst_ready", int'(bus.hash_ready), 0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("post_rst_buttons", int'(bus.control), 0);

    // Manual stepping with wrap in both directions
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("prev_wraps_to_8", int'(bus.control), 8);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("next_wraps_to_1", int'(bus.control), 1);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("both_buttons_hold", int'(bus.control), 1);
    idle(6, 1'b0);
    chk("manual_no_timer", int'(bus.control), 1);

    // show_normal at word 6 in AUTO, then resume with a fresh dwell
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(5 * DWELL, 1'b1);
    chk("auto_word6", int'(bus.control), 6);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("show_normal", int'(bus.control), 0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("resume_word6", int'(bus.control), 6);
    idle(DWELL - 1, 1'b1);
    chk("resume_dwell_hold", int'(bus.control), 6);
    idle(1, 1'b1);
    chk("resume_dwell_next", int'(bus.control), 7);

    // hash_valid overrides the current word and a same-cycle button
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("manual_word7", int'(bus.control), 7);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("hash_restarts", int'(bus.control), 1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("hash_beats_button", int'(bus.control), 1);

    // Random pulses on every input
    begin
      bit ae;
      ae = 1'b1;
      for (int i = 0; i < 10000; i++) begin
        if ($urandom_range(0, 99) < 3) ae = ~ae;
        step($urandom_range(0, 99) < 3, $urandom_range(0, 199) < 3,
             $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 8, ae);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
